// File: rtl/uart_rx_fifo_if.sv
// Bundle of receive-byte, pop and status signals between the receiver/core
// and the receive buffer.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
);
  logic [7:0]  rx_byte_i;
  logic        rx_ready_i;
  logic        pop_i;
  logic        clr_ovr_i;
  logic [7:0]  data_o;
  logic        empty_o;
  logic        full_o;
  logic [AW:0] count_o;
  logic        overrun_o;

  // Buffer side: consumes bytes and control pulses, produces status.
  modport slave (
    input  rx_byte_i, rx_ready_i, pop_i, clr_ovr_i,
    output data_o, empty_o, full_o, count_o, overrun_o
  );

  // Driver side: the receiver/core that feeds and drains the buffer.
  modport master (
    output rx_byte_i, rx_ready_i, pop_i, clr_ovr_i,
    input  data_o, empty_o, full_o, count_o, overrun_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: captures a byte on each rising edge of the receiver's
// byte-ready flag, presents the oldest byte, removes it on pop, and keeps a
// sticky overrun flag for bytes dropped while full.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  uart_rx_fifo_if.slave bus
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE  = (AW+1)'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rx_q;
  logic          r_overrun;

  logic w_push;
  logic w_pop_ok;
  logic w_push_ok;
  logic w_drop;
  logic w_empty;
  logic w_full;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == L_FULL);
  assign w_push    = bus.rx_ready_i & ~r_rx_q;
  // Pop on an empty FIFO is ignored, so a same-cycle push into empty never bypasses.
  assign w_pop_ok  = bus.pop_i & ~w_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_push_ok = w_push & (~w_full | w_pop_ok);
  assign w_drop    = w_push & ~w_push_ok;

  // Rising-edge detector; resets high so a flag already up at release is not a push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rx_q <= 1'b1;
    else         r_rx_q <= bus.rx_ready_i;
  end

  // Storage array, deliberately not reset; only written on an accepted push.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= bus.rx_byte_i;
  end

  // Pointers wrap naturally at DEPTH; count tracks accepted pushes minus pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + L_ONE;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - L_ONE;
    end
  end

  // Sticky overrun: a drop sets it and takes priority over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            r_overrun <= 1'b0;
    else if (w_drop)        r_overrun <= 1'b1;
    else if (bus.clr_ovr_i) r_overrun <= 1'b0;
  end

  // Outputs decode registered state only.
  assign bus.data_o    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.empty_o   = w_empty;
  assign bus.full_o    = w_full;
  assign bus.count_o   = r_count;
  assign bus.overrun_o = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a
// monitor compares the head byte on every effective pop.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo_if #(.DEPTH(16), .AW(4)) bus ();

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: at the falling edge, an effective pop presents its byte on data_o.
  always @(negedge clk) begin
    if (rst_n && bus.pop_i && !bus.empty_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got %0h expected nothing (scoreboard empty)", bus.data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_o !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", bus.data_o, e);
        end else begin
          $display("ok   pop_data: %0h", bus.data_o);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising edge on rx_ready with the byte, then drop it again.
  task automatic push_byte(input logic [7:0] b);
    bus.rx_byte_i  = b;
    bus.rx_ready_i = 1'b1;
    tick();
    bus.rx_ready_i = 1'b0;
    tick();
  endtask

  task automatic pop_once();
    bus.pop_i = 1'b1;
    tick();
    bus.pop_i = 1'b0;
  endtask

  initial begin
    bus.rx_byte_i  = 8'h00;
    bus.rx_ready_i = 1'b1;
    bus.pop_i      = 1'b0;
    bus.clr_ovr_i  = 1'b0;

    // Reset with receiver flag already high; no push on release.
    repeat (3) tick();
    check("rst_empty", {31'd0, bus.empty_o}, 32'd1);
    check("rst_data", {24'd0, bus.data_o}, 32'h00);
    rst_n = 1'b1;
    repeat (5) tick();
    check("held_high_count", {27'd0, bus.count_o}, 32'd0);
    check("held_high_empty", {31'd0, bus.empty_o}, 32'd1);
    check("held_high_full", {31'd0, bus.full_o}, 32'd0);
    check("held_high_ovr", {31'd0, bus.overrun_o}, 32'd0);
    bus.rx_ready_i = 1'b0;
    tick();
    bus.rx_byte_i  = 8'hA5;
    bus.rx_ready_i = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    check("first_push_count", {27'd0, bus.count_o}, 32'd1);
    check("first_push_data", {24'd0, bus.data_o}, 32'hA5);
    check("first_push_empty", {31'd0, bus.empty_o}, 32'd0);
    bus.rx_ready_i = 1'b0;
    tick();
    pop_once();
    check("after_pop_empty", {31'd0, bus.empty_o}, 32'd1);

    // Fill to full, overrun, then clear collision.
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(8'(i));
      push_byte(8'(i));
    end
    check("full_flag", {31'd0, bus.full_o}, 32'd1);
    check("full_count", {27'd0, bus.count_o}, 32'd16);
    check("full_head", {24'd0, bus.data_o}, 32'h01);
    push_byte(8'h11);
    check("ovr_set", {31'd0, bus.overrun_o}, 32'd1);
    check("ovr_count", {27'd0, bus.count_o}, 32'd16);
    bus.rx_byte_i  = 8'h12;
    bus.rx_ready_i = 1'b1;
    bus.clr_ovr_i  = 1'b1;
    tick();
    bus.rx_ready_i = 1'b0;
    bus.clr_ovr_i  = 1'b0;
    check("ovr_set_wins", {31'd0, bus.overrun_o}, 32'd1);
    check("ovr_drop_count", {27'd0, bus.count_o}, 32'd16);
    bus.clr_ovr_i = 1'b1;
    tick();
    bus.clr_ovr_i = 1'b0;
    check("ovr_cleared", {31'd0, bus.overrun_o}, 32'd0);
    for (int i = 0; i < 16; i++) pop_once();
    check("drain_empty", {31'd0, bus.empty_o}, 32'd1);
    check("drain_data", {24'd0, bus.data_o}, 32'h00);

    // Full FIFO, simultaneous push and pop.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      push_byte(8'h30 + 8'(i));
    end
    bus.rx_byte_i  = 8'h22;
    bus.rx_ready_i = 1'b1;
    bus.pop_i      = 1'b1;
    exp_q.push_back(8'h22);
    tick();
    bus.rx_ready_i = 1'b0;
    bus.pop_i      = 1'b0;
    check("pp_full_count", {27'd0, bus.count_o}, 32'd16);
    check("pp_full_ovr", {31'd0, bus.overrun_o}, 32'd0);
    check("pp_full_head", {24'd0, bus.data_o}, 32'h31);
    for (int i = 0; i < 16; i++) pop_once();
    check("pp_drain_empty", {31'd0, bus.empty_o}, 32'd1);

    // Pops on empty are ignored; push coincident with pop on empty keeps the byte.
    for (int i = 0; i < 3; i++) pop_once();
    check("underflow_count", {27'd0, bus.count_o}, 32'd0);
    bus.rx_byte_i  = 8'h5A;
    bus.rx_ready_i = 1'b1;
    bus.pop_i      = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    bus.rx_ready_i = 1'b0;
    bus.pop_i      = 1'b0;
    check("empty_pp_count", {27'd0, bus.count_o}, 32'd1);
    check("empty_pp_data", {24'd0, bus.data_o}, 32'h5A);
    pop_once();

    // Reset mid-stream with 10 bytes stored.
    for (int i = 0; i < 10; i++) push_byte(8'h70 + 8'(i));
    check("pre_rst_count", {27'd0, bus.count_o}, 32'd10);
    bus.clr_ovr_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", {27'd0, bus.count_o}, 32'd0);
    check("async_rst_empty", {31'd0, bus.empty_o}, 32'd1);
    check("async_rst_data", {24'd0, bus.data_o}, 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    push_byte(8'h3C);
    exp_q.push_back(8'h3C);
    check("post_rst_count", {27'd0, bus.count_o}, 32'd1);
    check("post_rst_data", {24'd0, bus.data_o}, 32'h3C);
    pop_once();
    tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between the `uart_rx` byte receiver and the GPIO load path.
- Captures each completed byte when `byte_ready` goes active and holds up to DEPTH bytes in arrival order.
- Presents the oldest byte to the GPIO read mux and removes it on an explicit pop from the core.
- Reports occupancy status and a sticky overrun flag, so bytes are no longer lost when software polls slowly.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- rx_byte_i  input  8  byte from the receiver; valid while rx_ready_i is high.
- rx_ready_i  input  1  receiver byte-ready flag; a byte is pushed on each 0->1 transition.
- pop_i  input  1  single-cycle pulse from the GPIO load path; removes the head byte.
- clr_ovr_i  input  1  single-cycle pulse; clears overrun_o.
- data_o  output  8  head byte; 8'h00 when empty.
- empty_o  output  1  FIFO holds 0 entries.
- full_o  output  1  FIFO holds DEPTH entries.
- count_o  output  AW+1  number of stored entries, 0..DEPTH.
- overrun_o  output  1  sticky; a byte arrived while the FIFO was full.

Behaviour:
- Reset values (rst_ni low, asynchronous):
  - wr_ptr, rd_ptr and count are 0.
  - empty_o=1, full_o=0, count_o=0, overrun_o=0, data_o=8'h00.
  - Edge-detect register rx_q resets to 1, so a receiver flag already high at reset release does not produce a push.
  - Storage array is not reset.
- Push detect:
  - push = rx_ready_i & ~rx_q; rx_q <= rx_ready_i every cycle.
  - A level held high for many cycles yields exactly one push.
  - A 1-cycle pulse also yields one push.
- Push (push=1, not full): mem[wr_ptr] <= rx_byte_i; wr_ptr increments; count increments.
- Pop (pop_i=1, not empty): rd_ptr increments; count decrements.
- Pop on empty is ignored: no pointer or count change, no error flag.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - If full at that time, the push is accepted, because the pop frees a slot, and overrun is not set.
  - If empty at that time, only the push takes effect; the pop is ignored (no bypass). Count becomes 1.
- Push when full without a simultaneous pop:
  - The byte is dropped and the pointers are unchanged.
  - overrun_o <= 1 at that edge.
- overrun_o clearing:
  - clr_ovr_i clears overrun_o at the next edge.
  - If a drop event and clr_ovr_i occur in the same cycle, set wins and overrun_o stays 1.
- Pointer arithmetic: pointers are AW bits and wrap DEPTH-1 -> 0 naturally. count is AW+1 bits and is never outside 0..DEPTH.
- Status outputs: empty_o = (count==0) and full_o = (count==DEPTH), both decoded from registered count. No combinational path from any input to any output.
- data_o timing:
  - data_o = mem[rd_ptr] when count!=0, else 8'h00.
  - It is updated from registered state, so a byte whose rising edge of rx_ready_i is sampled at edge N is visible on data_o after edge N.
  - After a pop at edge N, data_o shows the next entry after edge N.
- Latency:
  - rx_ready_i rise to empty_o low: 1 clock.
  - pop_i to the new head on data_o: 1 clock.
- Reset mid-operation:
  - All stored bytes are discarded and the outputs return to reset values immediately.
  - After release, the first push requires a fresh 0->1 on rx_ready_i.

Test Plan:
- Reset with rx_ready_i=1, release, hold high 5 cycles -> count_o stays 0, empty_o=1. Drop rx_ready_i, then raise it with 8'hA5 -> count_o=1, data_o=8'hA5 one clock later.
- Push 8'h01..8'h10 (16 bytes) -> full_o=1, count_o=16, data_o=8'h01. Push 8'h11 -> overrun_o=1, count_o=16. Pop 16 times -> data_o sequence 01..10, then empty_o=1, data_o=00.
- Full FIFO, push 8'h22 with pop_i in the same cycle -> count_o stays 16, overrun_o=0. After 16 further pops, the last byte read is 8'h22.
- Empty FIFO, pop_i pulses 3 times -> count_o=0, pointers unchanged. Next push of 8'h5A -> data_o=8'h5A (verifies no underflow corruption).
- Overrun set, then clr_ovr_i coincident with a dropped push -> overrun_o remains 1. clr_ovr_i alone on the next cycle -> overrun_o=0.
- Fill 10 bytes, assert rst_ni low mid-stream -> outputs go to reset values asynchronously. After release, push 8'h3C -> count_o=1, data_o=8'h3C.
